// File: rtl/sshooter_rom_pkg.sv
// Shared types and constants for the Scooter Shooter ROM download path.
// Region order matches the one-hot rom_we bit order.
package sshooter_rom_pkg;

  localparam int ROM_WE_W   = 5;
  localparam int ROM_ADDR_W = 17;
  localparam int IMG_ADDR_W = 25;

  typedef enum logic [2:0] {
    REGION_MAIN = 3'd0,
    REGION_SND  = 3'd1,
    REGION_CHAR = 3'd2,
    REGION_SPR  = 3'd3,
    REGION_PROM = 3'd4
  } region_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    DONE    = 2'd2
  } load_state_e;

  function automatic logic [ROM_WE_W-1:0] region_onehot(input region_e r);
    return ROM_WE_W'(1) << r;
  endfunction

endpackage

// File: rtl/sshooter_rom_region_decode.sv
// Combinational address-to-region decoder for the ROM image map.
// Produces the one-hot region select, the region base and an out-of-map flag.
import sshooter_rom_pkg::*;

module sshooter_rom_region_decode #(
  parameter logic [IMG_ADDR_W-1:0] MAIN_END = 25'h0C000,
  parameter logic [IMG_ADDR_W-1:0] SND_END  = 25'h0E000,
  parameter logic [IMG_ADDR_W-1:0] CHAR_END = 25'h12000,
  parameter logic [IMG_ADDR_W-1:0] SPR_END  = 25'h1A000,
  parameter logic [IMG_ADDR_W-1:0] PROM_END = 25'h1A500
) (
  input  logic [IMG_ADDR_W-1:0] addr_i,
  output logic [ROM_WE_W-1:0]   sel_o,
  output logic [IMG_ADDR_W-1:0] base_o,
  output logic                  oom_o
);

  region_e region;

  // First region whose exclusive end lies above the address wins.
  always_comb begin
    region = REGION_MAIN;
    base_o = '0;
    oom_o  = 1'b0;
    if (addr_i < MAIN_END) begin
      region = REGION_MAIN;
    end else if (addr_i < SND_END) begin
      region = REGION_SND;
      base_o = MAIN_END;
    end else if (addr_i < CHAR_END) begin
      region = REGION_CHAR;
      base_o = SND_END;
    end else if (addr_i < SPR_END) begin
      region = REGION_SPR;
      base_o = CHAR_END;
    end else if (addr_i < PROM_END) begin
      region = REGION_PROM;
      base_o = SPR_END;
    end else begin
      oom_o  = 1'b1;
    end
    sel_o = oom_o ? '0 : region_onehot(region);
  end

endmodule

// File: rtl/sshooter_rom_loader.sv
// Routes the HPS index-0 download stream into the Scooter Shooter ROM regions.
// Optional image checksum is enabled with the ROM_CHECKSUM_EN macro.
import sshooter_rom_pkg::*;

module sshooter_rom_loader #(
  parameter logic [IMG_ADDR_W-1:0] MAIN_END = 25'h0C000,
  parameter logic [IMG_ADDR_W-1:0] SND_END  = 25'h0E000,
  parameter logic [IMG_ADDR_W-1:0] CHAR_END = 25'h12000,
  parameter logic [IMG_ADDR_W-1:0] SPR_END  = 25'h1A000,
  parameter logic [IMG_ADDR_W-1:0] PROM_END = 25'h1A500
`ifdef ROM_CHECKSUM_EN
  , parameter logic [15:0]         EXPECT_SUM = 16'h0000
`endif
) (
  input  logic                  clk_49m,
  input  logic                  reset,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [IMG_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]            ioctl_data,
  output logic [ROM_WE_W-1:0]   rom_we,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic [7:0]            rom_data,
  output logic                  loading,
  output logic                  load_done,
  output logic                  load_err,
  output logic [IMG_ADDR_W-1:0] byte_count,
  output logic                  sum_ok
);

  load_state_e state_q, state_d;

  logic                  dl_q;
  logic                  relock_q;
  logic [ROM_WE_W-1:0]   rom_we_q;
  logic [ROM_ADDR_W-1:0] rom_addr_q;
  logic [7:0]            rom_data_q;
  logic [IMG_ADDR_W-1:0] byte_count_q, byte_count_d;
  logic                  load_err_q, load_err_d;

  logic                  idx_ok;
  logic                  accept;
  logic                  start;
  logic                  dl_end;
  logic                  take;
  logic [ROM_WE_W-1:0]   sel;
  logic [IMG_ADDR_W-1:0] base;
  logic                  oom;

  assign idx_ok = (ioctl_index == 8'd0);
  assign accept = ioctl_wr & ioctl_download & idx_ok;
  // relock_q blocks a spurious start when reset drops while a download is still running.
  assign start  = ioctl_download & ~dl_q & idx_ok & ~relock_q;
  assign dl_end = dl_q & ~ioctl_download;
  assign take   = accept & (start | (state_q == LOADING));

  sshooter_rom_region_decode #(
    .MAIN_END (MAIN_END),
    .SND_END  (SND_END),
    .CHAR_END (CHAR_END),
    .SPR_END  (SPR_END),
    .PROM_END (PROM_END)
  ) u_decode (
    .addr_i (ioctl_addr),
    .sel_o  (sel),
    .base_o (base),
    .oom_o  (oom)
  );

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = LOADING;
      LOADING: if (dl_end) state_d = DONE;
      DONE:    if (start)  state_d = LOADING;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      dl_q     <= 1'b0;
      relock_q <= 1'b1;
    end else begin
      dl_q <= ioctl_download;
      if (!ioctl_download) relock_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      rom_we_q   <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
    end else begin
      rom_we_q <= take ? sel : '0;
      if (take) begin
        rom_addr_q <= ROM_ADDR_W'(ioctl_addr - base);
        rom_data_q <= ioctl_data;
      end
    end
  end

  // Start clears first, then a same-cycle accept is applied on top.
  always_comb begin
    byte_count_d = byte_count_q;
    load_err_d   = load_err_q;
    if (start) begin
      byte_count_d = '0;
      load_err_d   = 1'b0;
    end
    if (take) begin
      if (byte_count_d != '1) byte_count_d = byte_count_d + 1'b1;
      if (oom) load_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      byte_count_q <= '0;
      load_err_q   <= 1'b0;
    end else begin
      byte_count_q <= byte_count_d;
      load_err_q   <= load_err_d;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = start ? 16'h0000 : sum_q;
    if (take && !oom) sum_d = sum_d + {8'h00, ioctl_data};
  end

  always_ff @(posedge clk_49m or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  always_comb begin
    loading = (state_q == LOADING);
`ifdef ROM_CHECKSUM_EN
    sum_ok  = (state_q == DONE) && (sum_q == EXPECT_SUM);
`else
    sum_ok  = 1'b1;
`endif
    load_done = (state_q == DONE) && (byte_count_q == PROM_END) &&
                !load_err_q && sum_ok;
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign load_err   = load_err_q;
  assign byte_count = byte_count_q;

endmodule
